pipe_adder: RTL

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 14 +
 rtl/pipe_adder_slice.sv | 22 ++
 rtl/pipe_adder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared constants and the per-slice result type for the pipelined adder.
// The slice result is sized for the widest supported slice; narrower slices zero-fill the upper bits.
package pipe_adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;
  localparam int SLICE_W_MAX    = 64;

  typedef struct packed {
    logic                   carry;
    logic [SLICE_W_MAX-1:0] sum;
  } slice_res_t;

endpackage

// File: rtl/pipe_adder_slice.sv
// adder_slice: purely combinational SW-bit add with carry in/out, one per pipeline stage.
module adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int SW = DEFAULT_WIDTH / DEFAULT_STAGES
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output slice_res_t    res
);

  logic [SW:0] full;

  always_comb begin
    full            = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    res             = '0;
    res.carry       = full[SW];
    res.sum[SW-1:0] = full[SW-1:0];
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder: STAGES slices chained through registered carries, with valid/ready flow control.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SW = WIDTH / STAGES;

  if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0 || SW > SLICE_W_MAX) begin : g_param_check
    $error("pipe_adder: WIDTH must be >= 2 and a multiple of STAGES >= 1, slice width <= SLICE_W_MAX");
  end

  logic              adv;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] valid_d, valid_q;
  logic [STAGES-1:0] carry_d, carry_q;

  // Stage k loads only when the whole pipe advances and a real transaction is arriving,
  // so bubbles and idle operand changes never disturb stored data.
  always_comb begin
    adv    = !valid_q[STAGES-1] || out_ready;
    vin    = '0;
    vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) vin[k] = valid_q[k-1];
    ld      = vin & {STAGES{adv}};
    valid_d = adv ? vin : valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];

  for (genvar j = 0; j < STAGES; j++) begin : g_slice
    logic [SW-1:0] a_in, b_in;
    logic          c_in;
    slice_res_t    res;
    logic [SW-1:0] sd_d [STAGES-j];
    logic [SW-1:0] sd_q [STAGES-j];

    if (j == 0) begin : g_head
      assign a_in = a[SW-1:0];
      assign b_in = b[SW-1:0];
      assign c_in = cin;
    end else begin : g_skew
      // Operand slice j rides a j-deep delay line so it meets the carry from slice j-1.
      logic [2*SW-1:0] op_d [j];
      logic [2*SW-1:0] op_q [j];

      always_comb begin
        op_d = op_q;
        if (ld[0]) op_d[0] = {a[j*SW +: SW], b[j*SW +: SW]};
        for (int i = 1; i < j; i++) begin
          if (ld[i]) op_d[i] = op_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < j; i++) op_q[i] <= '0;
        end else begin
          op_q <= op_d;
        end
      end

      assign {a_in, b_in} = op_q[j-1];
      assign c_in         = carry_q[j-1];
    end

    adder_slice #(.SW(SW)) u_slice (
      .a   (a_in),
      .b   (b_in),
      .cin (c_in),
      .res (res)
    );

    if (SW < SLICE_W_MAX) begin : g_pad
      logic pad_unused;
      assign pad_unused = |res.sum[SLICE_W_MAX-1:SW];
    end

    assign carry_d[j] = ld[j] ? res.carry : carry_q[j];

    // Finished sum slice j waits STAGES-1-j more stages so the whole word emerges together.
    always_comb begin
      sd_d = sd_q;
      if (ld[j]) sd_d[0] = res.sum[SW-1:0];
      for (int i = 1; i < STAGES - j; i++) begin
        if (ld[j+i]) sd_d[i] = sd_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < STAGES - j; i++) sd_q[i] <= '0;
      end else begin
        sd_q <= sd_d;
      end
    end

    assign sum[j*SW +: SW] = sd_q[STAGES-j-1];

`ifdef PIPE_ADDER_OVF_EN
    if (j == STAGES - 1) begin : g_ovf
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = ovf_q;
        if (ld[j]) ovf_d = (a_in[SW-1] ^ b_in[SW-1] ^ res.sum[SW-1]) ^ res.carry;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
      end

      assign ovf = ovf_q;
    end
`endif
  end

endmodule
